// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle control unit: ALU op codes, FSM states,
// RV32I opcodes and datapath mux selects.
package mc_pkg;

    localparam logic [3:0] ALU_AND  = 4'd0;
    localparam logic [3:0] ALU_OR   = 4'd1;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_XOR  = 4'd3;
    localparam logic [3:0] ALU_NOR  = 4'd4;
    localparam logic [3:0] ALU_SRL  = 4'd5;
    localparam logic [3:0] ALU_SUB  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd9;
    localparam logic [3:0] ALU_SLL  = 4'd14;
    localparam logic [3:0] ALU_SRA  = 4'd15;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXE_R    = 4'd2,
        S_EXE_I    = 4'd3,
        S_ALU_WB   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_LD_WB    = 4'd7,
        S_MEM_WR   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_ILLEGAL  = 4'd11
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [1:0] SRC_A_PC    = 2'd0;
    localparam logic [1:0] SRC_A_OLDPC = 2'd1;
    localparam logic [1:0] SRC_A_RS1   = 2'd2;

    localparam logic [1:0] SRC_B_RS2  = 2'd0;
    localparam logic [1:0] SRC_B_FOUR = 2'd1;
    localparam logic [1:0] SRC_B_IMM  = 2'd2;

    localparam logic [1:0] WB_ALUOUT = 2'd0;
    localparam logic [1:0] WB_MDR    = 2'd1;
    localparam logic [1:0] WB_PC     = 2'd2;

endpackage

// File: rtl/mc_ctrl_alu_op_decode.sv
// Maps (opcode, funct3, funct7) to the ALU op code; shared by the R-type,
// I-type and branch execute states.
module alu_op_decode
    import mc_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] alu_op,
    output logic       funct_illegal
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path can
        // leave it unassigned and infer a latch.
        alu_op        = ALU_ADD;
        funct_illegal = 1'b0;
        if (opcode == OP_BRANCH) begin
            case (funct3)
                3'b000, 3'b001: alu_op = ALU_SUB;
                3'b100, 3'b101: alu_op = ALU_SLT;
                3'b110, 3'b111: alu_op = ALU_SLTU;
                default:        funct_illegal = 1'b1;
            endcase
        end else if (opcode == OP_R || opcode == OP_I) begin
            case (funct3)
                3'b000:  alu_op = (opcode == OP_R && funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
                3'b001:  alu_op = ALU_SLL;
                3'b010:  alu_op = ALU_SLT;
                3'b011:  alu_op = ALU_SLTU;
                3'b100:  alu_op = ALU_XOR;
                3'b101:  alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
                3'b110:  alu_op = ALU_OR;
                default: alu_op = ALU_AND;
            endcase
            // I-type funct7 bits are immediate, so only R-type is screened.
            if (opcode == OP_R && funct7 != F7_BASE && funct7 != F7_ALT)
                funct_illegal = 1'b1;
        end
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for the RV32I-subset CPU: one state per cycle,
// outputs decoded combinationally from state, inst and the memory handshake.
module mc_ctrl
    import mc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst,
    input  logic        zero,
    input  logic        mem_ack,
    output logic [3:0]  ALU_operation,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic        mem_read,
    output logic        mem_write,
    output logic        iord,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic        illegal,
    output logic [3:0]  state
);

    state_t     state_q;
    state_t     state_n;
    logic       illegal_q;
    logic [3:0] dec_op;
    logic       dec_illegal;
    logic       taken;
    logic       unused_inst;

    assign unused_inst = ^{inst[24:15], inst[11:7]};

    alu_op_decode u_alu_op_decode (
        .opcode        (inst[6:0]),
        .funct3        (inst[14:12]),
        .funct7        (inst[31:25]),
        .alu_op        (dec_op),
        .funct_illegal (dec_illegal)
    );

    // SUB leaves zero set on equality; SLT/SLTU clear zero when less-than.
    always_comb begin
        case (inst[14:12])
            3'b000:         taken = zero;
            3'b001:         taken = ~zero;
            3'b100, 3'b110: taken = ~zero;
            3'b101, 3'b111: taken = zero;
            default:        taken = 1'b0;
        endcase
    end

    always_comb begin
        state_n       = state_q;
        ALU_operation = ALU_AND;
        alu_src_a     = SRC_A_PC;
        alu_src_b     = SRC_B_RS2;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_src        = 1'b0;
        reg_write     = 1'b0;
        wb_sel        = WB_ALUOUT;
        case (state_q)
            S_FETCH: begin
                mem_read      = 1'b1;
                alu_src_a     = SRC_A_PC;
                alu_src_b     = SRC_B_FOUR;
                ALU_operation = ALU_ADD;
                if (mem_ack) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_n  = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a     = SRC_A_OLDPC;
                alu_src_b     = SRC_B_IMM;
                ALU_operation = ALU_ADD;
                case (inst[6:0])
                    OP_R:               state_n = S_EXE_R;
                    OP_I:               state_n = S_EXE_I;
                    OP_LOAD, OP_STORE:  state_n = S_MEM_ADDR;
                    OP_BRANCH:          state_n = S_BRANCH;
                    OP_JAL:             state_n = S_JAL;
                    default:            state_n = S_ILLEGAL;
                endcase
            end
            S_EXE_R: begin
                alu_src_a     = SRC_A_RS1;
                alu_src_b     = SRC_B_RS2;
                ALU_operation = dec_op;
                state_n       = dec_illegal ? S_ILLEGAL : S_ALU_WB;
            end
            S_EXE_I: begin
                alu_src_a     = SRC_A_RS1;
                alu_src_b     = SRC_B_IMM;
                ALU_operation = dec_op;
                state_n       = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
                wb_sel    = WB_ALUOUT;
                state_n   = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a     = SRC_A_RS1;
                alu_src_b     = SRC_B_IMM;
                ALU_operation = ALU_ADD;
                state_n       = (inst[6:0] == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ack) state_n = S_LD_WB;
            end
            S_LD_WB: begin
                reg_write = 1'b1;
                wb_sel    = WB_MDR;
                state_n   = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ack) state_n = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = SRC_A_RS1;
                alu_src_b     = SRC_B_RS2;
                pc_src        = 1'b1;
                ALU_operation = dec_op;
                if (dec_illegal) begin
                    state_n = S_ILLEGAL;
                end else begin
                    pc_write = taken;
                    state_n  = S_FETCH;
                end
            end
            S_JAL: begin
                reg_write = 1'b1;
                wb_sel    = WB_PC;
                pc_write  = 1'b1;
                pc_src    = 1'b1;
                state_n   = S_FETCH;
            end
            S_ILLEGAL: state_n = S_ILLEGAL;
            default:   state_n = S_FETCH;
        endcase

        // Reset masks the strobes combinationally so they drop in the same
        // cycle rst rises, not one edge later.
        if (rst) begin
            ALU_operation = ALU_AND;
            alu_src_a     = SRC_A_PC;
            alu_src_b     = SRC_B_RS2;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            iord          = 1'b0;
            ir_write      = 1'b0;
            pc_write      = 1'b0;
            pc_src        = 1'b0;
            reg_write     = 1'b0;
            wb_sel        = WB_ALUOUT;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_n;
            if (state_n == S_ILLEGAL) illegal_q <= 1'b1;
        end
    end

    assign state   = state_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: a per-instruction cycle schedule built from the
// latency/strobe rules is compared every cycle, plus literal spot checks.
module tb_mc_ctrl;
    import mc_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst;
    logic        zero;
    logic        mem_ack;
    logic [3:0]  ALU_operation;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic        mem_read;
    logic        mem_write;
    logic        iord;
    logic        ir_write;
    logic        pc_write;
    logic        pc_src;
    logic        reg_write;
    logic [1:0]  wb_sel;
    logic        illegal;
    logic [3:0]  state;

    mc_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .inst          (inst),
        .zero          (zero),
        .mem_ack       (mem_ack),
        .ALU_operation (ALU_operation),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .iord          (iord),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_src        (pc_src),
        .reg_write     (reg_write),
        .wb_sel        (wb_sel),
        .illegal       (illegal),
        .state         (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic       chk_st;  logic [3:0] st;
        logic       mr, mw, irw, pcw, rw;
        logic       chk_op;  logic [3:0] op;
        logic       chk_a;   logic [1:0] a;
        logic       chk_b;   logic [1:0] b;
        logic       chk_iord; logic      iord;
        logic       chk_pcs; logic       pcs;
        logic       chk_wb;  logic [1:0] wb;
        logic       chk_ill; logic       ill;
    } exp_t;

    typedef struct {
        logic [3:0] st;
        logic [3:0] op;
        logic       mr, mw, rw, pcw, pcs, iord;
        logic [1:0] wb;
    } snap_t;

    int    total = 0;
    int    bad   = 0;
    exp_t  exp_cur;
    snap_t hist[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (exp_cur.valid === 1'b1) begin
            snap_t s;
            if (exp_cur.chk_st)   check("state", state, exp_cur.st);
            check("mem_read",  mem_read,  exp_cur.mr);
            check("mem_write", mem_write, exp_cur.mw);
            check("ir_write",  ir_write,  exp_cur.irw);
            check("pc_write",  pc_write,  exp_cur.pcw);
            check("reg_write", reg_write, exp_cur.rw);
            if (exp_cur.chk_op)   check("alu_op",    ALU_operation, exp_cur.op);
            if (exp_cur.chk_a)    check("alu_src_a", alu_src_a, exp_cur.a);
            if (exp_cur.chk_b)    check("alu_src_b", alu_src_b, exp_cur.b);
            if (exp_cur.chk_iord) check("iord",      iord,      exp_cur.iord);
            if (exp_cur.chk_pcs)  check("pc_src",    pc_src,    exp_cur.pcs);
            if (exp_cur.chk_wb)   check("wb_sel",    wb_sel,    exp_cur.wb);
            if (exp_cur.chk_ill)  check("illegal",   illegal,   exp_cur.ill);
            s.st = state; s.op = ALU_operation; s.mr = mem_read; s.mw = mem_write;
            s.rw = reg_write; s.pcw = pc_write; s.pcs = pc_src; s.iord = iord; s.wb = wb_sel;
            hist.push_back(s);
        end
    end

    // ---------------- reference model ----------------
    function automatic exp_t base(input logic [3:0] st);
        exp_t e;
        e.valid = 1'b1; e.chk_st = 1'b1; e.st = st;
        e.mr = 1'b0; e.mw = 1'b0; e.irw = 1'b0; e.pcw = 1'b0; e.rw = 1'b0;
        e.chk_op = 1'b0; e.op = '0; e.chk_a = 1'b0; e.a = '0; e.chk_b = 1'b0; e.b = '0;
        e.chk_iord = 1'b0; e.iord = 1'b0; e.chk_pcs = 1'b0; e.pcs = 1'b0;
        e.chk_wb = 1'b0; e.wb = '0; e.chk_ill = 1'b1; e.ill = 1'b0;
        return e;
    endfunction

    function automatic exp_t fetch_exp(input logic ack);
        exp_t e = base(S_FETCH);
        e.mr = 1'b1; e.chk_iord = 1'b1; e.iord = 1'b0;
        e.chk_a = 1'b1; e.a = SRC_A_PC; e.chk_b = 1'b1; e.b = SRC_B_FOUR;
        e.chk_op = 1'b1; e.op = ALU_ADD;
        if (ack) begin
            e.irw = 1'b1; e.pcw = 1'b1; e.chk_pcs = 1'b1; e.pcs = 1'b0;
        end
        return e;
    endfunction

    // Mnemonic-level op lookup: add/sub, sll, slt, sltu, xor, srl/sra, or, and.
    function automatic logic [3:0] ref_op(input logic [31:0] i);
        logic [2:0] f3;
        f3 = i[14:12];
        if (i[6:0] == OP_BRANCH)
            return (f3 < 3'd2) ? ALU_SUB : (f3 < 3'd6) ? ALU_SLT : ALU_SLTU;
        case (f3)
            3'd0:    return (i[6:0] == OP_R && i[31:25] == 7'h20) ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return i[30] ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic logic ref_taken(input logic [31:0] i, input logic z);
        logic eq, lt;
        eq = z;
        lt = ~z;
        case (i[14:12])
            3'd0:       return eq;
            3'd1:       return ~eq;
            3'd4, 3'd6: return lt;
            3'd5, 3'd7: return ~lt;
            default:    return 1'b0;
        endcase
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic do_cycle(input exp_t e, input logic r, input logic ack,
                            input logic z, input logic [31:0] i);
        @(posedge clk); #1;
        rst = r; mem_ack = ack; zero = z; inst = i; exp_cur = e;
    endtask

    task automatic settle();
        @(negedge clk); #1;
    endtask

    task automatic rst_cycles(input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e = base(S_FETCH);
            e.chk_op = 1'b1; e.chk_a = 1'b1; e.chk_b = 1'b1;
            e.chk_iord = 1'b1; e.chk_pcs = 1'b1; e.chk_wb = 1'b1;
            if (k == 0) begin
                e.chk_st = 1'b0; e.chk_ill = 1'b0;
            end
            do_cycle(e, 1'b1, 1'b1, 1'b0, 32'h0);
        end
    endtask

    task automatic hold_illegal(input int n, input logic [31:0] i);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e = base(S_ILLEGAL);
            e.ill = 1'b1;
            do_cycle(e, 1'b0, k[0], k[1], i);
        end
    endtask

    // One instruction from FETCH to its last state; stops at the deciding
    // cycle when the instruction turns out illegal.
    task automatic run_instr(input logic [31:0] i, input int fw, input int mw,
                             input logic z, input logic noise);
        exp_t e;
        logic is_r;
        hist.delete();
        for (int k = 0; k < fw; k++) do_cycle(fetch_exp(1'b0), 1'b0, 1'b0, z, i);
        do_cycle(fetch_exp(1'b1), 1'b0, 1'b1, z, i);
        e = base(S_DECODE);
        e.chk_a = 1'b1; e.a = SRC_A_OLDPC; e.chk_b = 1'b1; e.b = SRC_B_IMM;
        e.chk_op = 1'b1; e.op = ALU_ADD;
        do_cycle(e, 1'b0, noise, z, i);
        case (i[6:0])
            OP_R, OP_I: begin
                is_r = (i[6:0] == OP_R);
                e = base(is_r ? S_EXE_R : S_EXE_I);
                e.chk_a = 1'b1; e.a = SRC_A_RS1;
                e.chk_b = 1'b1; e.b = is_r ? SRC_B_RS2 : SRC_B_IMM;
                if (!is_r || i[31:25] == 7'h00 || i[31:25] == 7'h20) begin
                    e.chk_op = 1'b1; e.op = ref_op(i);
                    do_cycle(e, 1'b0, noise, z, i);
                    e = base(S_ALU_WB);
                    e.rw = 1'b1; e.chk_wb = 1'b1; e.wb = WB_ALUOUT;
                    do_cycle(e, 1'b0, noise, z, i);
                end else begin
                    do_cycle(e, 1'b0, noise, z, i);
                end
            end
            OP_LOAD, OP_STORE: begin
                e = base(S_MEM_ADDR);
                e.chk_a = 1'b1; e.a = SRC_A_RS1; e.chk_b = 1'b1; e.b = SRC_B_IMM;
                e.chk_op = 1'b1; e.op = ALU_ADD;
                do_cycle(e, 1'b0, noise, z, i);
                for (int k = 0; k <= mw; k++) begin
                    if (i[6:0] == OP_LOAD) begin
                        e = base(S_MEM_RD); e.mr = 1'b1;
                    end else begin
                        e = base(S_MEM_WR); e.mw = 1'b1;
                    end
                    e.chk_iord = 1'b1; e.iord = 1'b1;
                    do_cycle(e, 1'b0, (k == mw), z, i);
                end
                if (i[6:0] == OP_LOAD) begin
                    e = base(S_LD_WB);
                    e.rw = 1'b1; e.chk_wb = 1'b1; e.wb = WB_MDR;
                    do_cycle(e, 1'b0, noise, z, i);
                end
            end
            OP_BRANCH: begin
                e = base(S_BRANCH);
                e.chk_a = 1'b1; e.a = SRC_A_RS1; e.chk_b = 1'b1; e.b = SRC_B_RS2;
                e.chk_pcs = 1'b1; e.pcs = 1'b1;
                if (i[14:12] != 3'd2 && i[14:12] != 3'd3) begin
                    e.chk_op = 1'b1; e.op = ref_op(i);
                    e.pcw = ref_taken(i, z);
                end
                do_cycle(e, 1'b0, noise, z, i);
            end
            OP_JAL: begin
                e = base(S_JAL);
                e.rw = 1'b1; e.chk_wb = 1'b1; e.wb = WB_PC;
                e.pcw = 1'b1; e.chk_pcs = 1'b1; e.pcs = 1'b1;
                do_cycle(e, 1'b0, noise, z, i);
            end
            default: ;
        endcase
        settle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [31:0] r_vec [8];

    initial begin
        exp_t e;
        exp_cur.valid = 1'b0;
        rst = 1'b1; mem_ack = 1'b0; zero = 1'b0; inst = 32'h0;

        // Reset, then FETCH waiting on memory.
        rst_cycles(3);
        settle();
        check("reset_illegal", illegal, 1'b0);
        for (int k = 0; k < 3; k++) do_cycle(fetch_exp(1'b0), 1'b0, 1'b0, 1'b0, 32'h0);
        settle();
        check("fetch_mem_read", mem_read, 1'b1);
        check("fetch_op", ALU_operation, 4'd2);
        check("fetch_src_b", alu_src_b, 2'd1);
        check("fetch_hold", state, S_FETCH);

        // R-type add / sub / sra with literal spot checks.
        run_instr(32'h002081B3, 0, 0, 1'b0, 1'b0);
        check("add_op", hist[2].op, 4'd2);
        check("add_wb_cycle4", hist[3].rw, 1'b1);
        run_instr(32'h402081B3, 0, 0, 1'b0, 1'b1);
        check("sub_op", hist[2].op, 4'd6);
        run_instr(32'h4020D1B3, 1, 0, 1'b0, 1'b0);
        check("sra_op", hist[3].op, 4'd15);

        // Remaining R-type and I-type ops against the model only.
        r_vec = '{32'h002091B3, 32'h0020A1B3, 32'h0020B1B3, 32'h0020C1B3,
                  32'h0020D1B3, 32'h0020E1B3, 32'h0020F1B3, 32'h00500093};
        for (int k = 0; k < 8; k++) run_instr(r_vec[k], k % 2, 0, 1'b0, k[0]);
        run_instr(32'h4010D093, 0, 0, 1'b0, 1'b1);
        run_instr(32'h0050A093, 0, 0, 1'b0, 1'b0);
        run_instr(32'h0050B093, 2, 0, 1'b0, 1'b1);

        // Load with three memory wait cycles: 8 cycles total.
        run_instr(32'h0080A283, 0, 3, 1'b0, 1'b0);
        for (int k = 3; k < 7; k++) begin
            check("lw_rd_mem_read", hist[k].mr, 1'b1);
            check("lw_rd_iord", hist[k].iord, 1'b1);
        end
        check("lw_ld_wb_state", hist[7].st, S_LD_WB);
        check("lw_ld_wb_rw", hist[7].rw, 1'b1);
        check("lw_ld_wb_sel", hist[7].wb, 2'd1);
        run_instr(32'h0080A283, 2, 0, 1'b0, 1'b1);

        // Stores.
        run_instr(32'h0020A423, 0, 0, 1'b0, 1'b0);
        run_instr(32'h0020A423, 1, 2, 1'b0, 1'b1);

        // Branches and JAL.
        run_instr(32'h00208463, 0, 0, 1'b1, 1'b0);
        check("beq_pc_write", hist[2].pcw, 1'b1);
        check("beq_pc_src", hist[2].pcs, 1'b1);
        check("beq_op", hist[2].op, 4'd6);
        run_instr(32'h00209463, 0, 0, 1'b1, 1'b0);
        check("bne_pc_write", hist[2].pcw, 1'b0);
        run_instr(32'h0020C463, 0, 0, 1'b0, 1'b1);
        check("blt_op", hist[2].op, 4'd9);
        run_instr(32'h00208463, 0, 0, 1'b0, 1'b0);
        run_instr(32'h00209463, 0, 0, 1'b0, 1'b1);
        run_instr(32'h0020D463, 0, 0, 1'b1, 1'b0);
        run_instr(32'h0020E463, 1, 0, 1'b0, 1'b0);
        run_instr(32'h0020F463, 0, 0, 1'b0, 1'b1);
        run_instr(32'h008000EF, 0, 0, 1'b0, 1'b1);
        check("jal_wb_sel", hist[2].wb, 2'd2);

        // Branch funct3=010 is illegal and must not write PC.
        run_instr(32'h0020A463, 0, 0, 1'b1, 1'b0);
        check("bad_branch_pcw", hist[2].pcw, 1'b0);
        hold_illegal(4, 32'h0020A463);
        settle();
        check("bad_branch_illegal", illegal, 1'b1);
        rst_cycles(2);

        // All-zero instruction: sticky ILLEGAL for 20 cycles, cleared by reset.
        run_instr(32'h00000000, 0, 0, 1'b0, 1'b1);
        hold_illegal(20, 32'h00000000);
        settle();
        check("illegal_sticky", illegal, 1'b1);
        rst_cycles(2);
        settle();
        check("illegal_cleared", illegal, 1'b0);
        check("illegal_reset_state", state, S_FETCH);

        // R-type with unsupported funct7 goes illegal.
        run_instr(32'h022081B3, 0, 0, 1'b0, 1'b0);
        hold_illegal(3, 32'h022081B3);
        rst_cycles(1);

        // Reset asserted mid-store drops mem_write immediately.
        run_instr(32'h00000013, 0, 0, 1'b0, 1'b0);
        do_cycle(fetch_exp(1'b1), 1'b0, 1'b1, 1'b0, 32'h0020A423);
        e = base(S_DECODE);
        do_cycle(e, 1'b0, 1'b0, 1'b0, 32'h0020A423);
        e = base(S_MEM_ADDR);
        do_cycle(e, 1'b0, 1'b0, 1'b0, 32'h0020A423);
        e = base(S_MEM_WR); e.mw = 1'b1;
        do_cycle(e, 1'b0, 1'b0, 1'b0, 32'h0020A423);
        e = base(S_MEM_WR);
        e.chk_op = 1'b1; e.chk_a = 1'b1; e.chk_b = 1'b1; e.chk_iord = 1'b1; e.chk_wb = 1'b1;
        do_cycle(e, 1'b1, 1'b0, 1'b0, 32'h0020A423);
        settle();
        check("store_rst_mem_write", mem_write, 1'b0);
        do_cycle(fetch_exp(1'b0), 1'b0, 1'b0, 1'b0, 32'h0020A423);
        settle();
        check("store_rst_fetch", state, S_FETCH);
        check("store_rst_mem_read", mem_read, 1'b1);

        exp_cur.valid = 1'b0;
        @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
